// File: rtl/sc_to_binary.sv
// Stochastic-to-binary converter: counts ones over a window of 2**LENGTH valid
// stream bits and returns (ones * maxnum) >> LENGTH on a valid/ready output.
module sc_to_binary #(
    parameter int LENGTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        maxnum,
    input  logic              SCnum,
    input  logic              sc_valid,
    output logic [LENGTH-1:0] Bnum,
    output logic              bnum_valid,
    input  logic              bnum_ready,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int PW = LENGTH + 9;
    localparam logic [PW-1:0] MAX_B = {{9{1'b0}}, {LENGTH{1'b1}}};

    logic [1:0]        state;
    logic [LENGTH:0]   ones;
    logic [LENGTH-1:0] bitcnt;
    logic [7:0]        maxnum_q;

    logic [LENGTH:0]   ones_final;
    logic [PW-1:0]     product;
    logic [PW-1:0]     prod_shift;
    logic [LENGTH-1:0] bnum_next;

    // ones_final can reach 2**LENGTH, hence the extra counter bit; the
    // shifted product only exceeds the output range when LENGTH < 8.
    always_comb begin
        ones_final = ones + {{LENGTH{1'b0}}, SCnum};
        product    = {8'b0, ones_final} * {{(LENGTH + 1){1'b0}}, maxnum_q};
        prod_shift = product >> LENGTH;
        bnum_next  = (prod_shift > MAX_B) ? {LENGTH{1'b1}} : prod_shift[LENGTH-1:0];
    end

    // Output handshake: Bnum is transferred on any rising edge where
    // bnum_valid && bnum_ready; bnum_valid and Bnum hold steady until then.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            Bnum       <= '0;
            bnum_valid <= 1'b0;
            ones       <= '0;
            bitcnt     <= '0;
            maxnum_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ACCUM;
                        ones     <= '0;
                        bitcnt   <= '0;
                        maxnum_q <= maxnum;
                    end
                end
                S_ACCUM: begin
                    if (start) begin
                        ones     <= '0;
                        bitcnt   <= '0;
                        maxnum_q <= maxnum;
                    end else if (sc_valid) begin
                        ones   <= ones_final;
                        bitcnt <= bitcnt + LENGTH'(1);
                        if (&bitcnt) begin
                            state      <= S_DONE;
                            Bnum       <= bnum_next;
                            bnum_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bnum_ready) begin
                        bnum_valid <= 1'b0;
                        if (start) begin
                            state    <= S_ACCUM;
                            ones     <= '0;
                            bitcnt   <= '0;
                            maxnum_q <= maxnum;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state == S_ACCUM);
    assign state_dbg = state;

endmodule
